// File: rtl/cdb_pkg.sv
// Shared constants, unit indices and broadcast record for the CDB arbiter.
package cdb_pkg;

  localparam int REQ_INT  = 0;
  localparam int REQ_LDST = 1;
  localparam int REQ_MUL  = 2;
  localparam int REQ_DIV  = 3;

  localparam int CDB_TAG_WIDTH  = 6;
  localparam int CDB_DATA_WIDTH = 32;
  localparam int PERF_CNT_W     = 16;

  typedef struct packed {
    logic                      valid;
    logic [CDB_TAG_WIDTH-1:0]  tag;
    logic [CDB_DATA_WIDTH-1:0] data;
    logic                      branch;
    logic                      branch_taken;
  } cdb_bcast_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (v == {PERF_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority picker; first request at or after ptr wins.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] winner,
  output logic          any
);

  always_comb begin
    int idx;
    idx    = 0;
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      // Modulo keeps the scan correct for non-power-of-two N.
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        winner     = PW'(idx);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the shared Common Data Bus; registers the winner onto the CDB.
// Define CDB_PERF_CNT_EN to add saturating grant/conflict performance counters.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int TAG_WIDTH  = CDB_TAG_WIDTH,
  parameter int DATA_WIDTH = CDB_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          int_branch,
  input  logic                          int_branch_taken,
  input  logic                          flush,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          CDB_valid,
  output logic [TAG_WIDTH-1:0]          CDB_tag,
  output logic [DATA_WIDTH-1:0]         CDB_data,
  output logic                          CDB_branch,
  output logic                          CDB_branch_taken
`ifdef CDB_PERF_CNT_EN
  ,
  output logic [NUM_REQ*16-1:0]         perf_grant_cnt,
  output logic [15:0]                   perf_conflict_cnt
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   winner;
  logic [NUM_REQ-1:0] pick_grant;
  logic               pick_any;
  logic               grant_fire;
  cdb_bcast_t         cdb_q, cdb_d;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PTR_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .grant  (pick_grant),
    .winner (winner),
    .any    (pick_any)
  );

  // Grant is masked while reset is held so requesters never see a phantom handshake.
  assign grant_fire = pick_any && !flush && reset;
  assign grant      = grant_fire ? pick_grant : '0;

  always_comb begin
    cdb_d              = cdb_q;
    cdb_d.valid        = 1'b0;
    cdb_d.branch       = 1'b0;
    cdb_d.branch_taken = 1'b0;
    ptr_d              = ptr_q;
    if (grant_fire) begin
      cdb_d.valid = 1'b1;
      cdb_d.tag   = req_tag[int'(winner)*TAG_WIDTH +: TAG_WIDTH];
      cdb_d.data  = req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
      if (winner == PTR_W'(REQ_INT)) begin
        cdb_d.branch       = int_branch;
        cdb_d.branch_taken = int_branch_taken;
      end
      ptr_d = (winner == PTR_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cdb_q <= '0;
      ptr_q <= '0;
    end else begin
      cdb_q <= cdb_d;
      ptr_q <= ptr_d;
    end
  end

  assign CDB_valid        = cdb_q.valid;
  assign CDB_tag          = cdb_q.tag;
  assign CDB_data         = cdb_q.data;
  assign CDB_branch       = cdb_q.branch;
  assign CDB_branch_taken = cdb_q.branch_taken;

`ifdef CDB_PERF_CNT_EN
  logic [NUM_REQ-1:0][15:0] gcnt_q, gcnt_d;
  logic [15:0]              conflict_q, conflict_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_gcnt
      always_comb gcnt_d[gi] = grant[gi] ? sat_inc(gcnt_q[gi]) : gcnt_q[gi];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) gcnt_q[gi] <= '0;
        else        gcnt_q[gi] <= gcnt_d[gi];
      end

      assign perf_grant_cnt[gi*16 +: 16] = gcnt_q[gi];
    end
  endgenerate

  // A conflict is any unflushed cycle where two or more units compete.
  always_comb begin
    conflict_d = conflict_q;
    if (!flush && ($countones(req) >= 2)) conflict_d = sat_inc(conflict_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) conflict_q <= '0;
    else        conflict_q <= conflict_d;
  end

  assign perf_conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed table-driven bench for cdb_arbiter, plus reset sequences.
module tb_cdb_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [23:0] req_tag;
  logic [127:0] req_data;
  logic        int_branch;
  logic        int_branch_taken;
  logic        flush;
  logic [3:0]  grant;
  logic        CDB_valid;
  logic [5:0]  CDB_tag;
  logic [31:0] CDB_data;
  logic        CDB_branch;
  logic        CDB_branch_taken;

  int checks = 0;
  int errors = 0;

  cdb_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .req              (req),
    .req_tag          (req_tag),
    .req_data         (req_data),
    .int_branch       (int_branch),
    .int_branch_taken (int_branch_taken),
    .flush            (flush),
    .grant            (grant),
    .CDB_valid        (CDB_valid),
    .CDB_tag          (CDB_tag),
    .CDB_data         (CDB_data),
    .CDB_branch       (CDB_branch),
    .CDB_branch_taken (CDB_branch_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic        flush;
    logic        ib;
    logic        ibt;
    logic [3:0]  grant;
    logic        valid;
    logic [5:0]  tag;
    logic [31:0] data;
    logic        br;
    logic        tk;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  localparam logic [5:0]  T0 = 6'd5,  T1 = 6'd9,  T2 = 6'd17, T3 = 6'd33;
  localparam logic [31:0] D0 = 32'h1111_0000, D1 = 32'h1111_0001;
  localparam logic [31:0] D2 = 32'hDEAD_BEEF, D3 = 32'h3333_0003;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic f, input logic ib, input logic ibt,
                              input logic [3:0] g, input logic v, input logic [5:0] t,
                              input logic [31:0] d, input logic br, input logic tk);
    vec_t x;
    x.req = r; x.flush = f; x.ib = ib; x.ibt = ibt; x.grant = g;
    x.valid = v; x.tag = t; x.data = d; x.br = br; x.tk = tk;
    return x;
  endfunction

  initial begin
    // Full contention from ptr=0: 0,1,2,3,0,1,2,3
    vecs[0]  = mk(4'b1111, 0, 0, 0, 4'b0001, 1, T0, D0, 0, 0);
    vecs[1]  = mk(4'b1111, 0, 0, 0, 4'b0010, 1, T1, D1, 0, 0);
    vecs[2]  = mk(4'b1111, 0, 0, 0, 4'b0100, 1, T2, D2, 0, 0);
    vecs[3]  = mk(4'b1111, 0, 0, 0, 4'b1000, 1, T3, D3, 0, 0);
    vecs[4]  = mk(4'b1111, 0, 0, 0, 4'b0001, 1, T0, D0, 0, 0);
    vecs[5]  = mk(4'b1111, 0, 0, 0, 4'b0010, 1, T1, D1, 0, 0);
    vecs[6]  = mk(4'b1111, 0, 0, 0, 4'b0100, 1, T2, D2, 0, 0);
    vecs[7]  = mk(4'b1111, 0, 0, 0, 4'b1000, 1, T3, D3, 0, 0);
    // Idle: tag/data hold
    vecs[8]  = mk(4'b0000, 0, 0, 0, 4'b0000, 0, T3, D3, 0, 0);
    // Single requester (mul, tag 17, DEADBEEF); ptr -> 3
    vecs[9]  = mk(4'b0100, 0, 0, 0, 4'b0100, 1, T2, D2, 0, 0);
    // ptr=3, scan wraps to 0: integer branch taken; ptr -> 1
    vecs[10] = mk(4'b0101, 0, 1, 1, 4'b0001, 1, T0, D0, 1, 1);
    // Flush: no grant, branch cleared, ptr stays 1
    vecs[11] = mk(4'b1010, 1, 1, 1, 4'b0000, 0, T0, D0, 0, 0);
    // Flush drops: unit 1 wins; ptr -> 2
    vecs[12] = mk(4'b1010, 0, 0, 0, 4'b0010, 1, T1, D1, 0, 0);
    // mul wins while int_branch=1 -> no branch; ptr -> 3
    vecs[13] = mk(4'b1100, 0, 1, 1, 4'b0100, 1, T2, D2, 0, 0);
    // Wrap: unit 3 wins, ptr -> 0
    vecs[14] = mk(4'b1000, 0, 0, 0, 4'b1000, 1, T3, D3, 0, 0);
    // Integer branch not taken
    vecs[15] = mk(4'b0001, 0, 1, 0, 4'b0001, 1, T0, D0, 1, 0);
    // Back-to-back same unit when alone
    vecs[16] = mk(4'b0001, 0, 0, 0, 4'b0001, 1, T0, D0, 0, 0);
    vecs[17] = mk(4'b0000, 0, 0, 0, 4'b0000, 0, T0, D0, 0, 0);

    req_tag          = {T3, T2, T1, T0};
    req_data         = {D3, D2, D1, D0};
    reset            = 1'b0;
    req              = 4'b1111;
    flush            = 1'b0;
    int_branch       = 1'b0;
    int_branch_taken = 1'b0;

    // Held in reset with all requesting
    @(posedge clk); #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_valid", 32'(CDB_valid), 32'h0);
    chk("rst_tag",   32'(CDB_tag), 32'h0);
    chk("rst_data",  CDB_data, 32'h0);
    chk("rst_branch", 32'(CDB_branch), 32'h0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      req              = vecs[i].req;
      flush            = vecs[i].flush;
      int_branch       = vecs[i].ib;
      int_branch_taken = vecs[i].ibt;
      #3;
      chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].grant));
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), 32'(CDB_valid), 32'(vecs[i].valid));
      chk($sformatf("v%0d_tag", i),   32'(CDB_tag), 32'(vecs[i].tag));
      chk($sformatf("v%0d_data", i),  CDB_data, vecs[i].data);
      chk($sformatf("v%0d_br", i),    32'(CDB_branch), 32'(vecs[i].br));
      chk($sformatf("v%0d_tk", i),    32'(CDB_branch_taken), 32'(vecs[i].tk));
      $display("vec %0d req=%b flush=%b grant=%b cdb_valid=%b tag=%0d data=%h br=%b tk=%b",
               i, vecs[i].req, vecs[i].flush, grant, CDB_valid, CDB_tag, CDB_data,
               CDB_branch, CDB_branch_taken);
    end

    // Async reset mid-broadcast: ptr is 1 here, unit 1 wins and moves ptr to 2
    req        = 4'b0010;
    int_branch = 1'b0;
    #3;
    chk("mid_grant", 32'(grant), 32'b0010);
    @(posedge clk); #1;
    chk("mid_valid_pre", 32'(CDB_valid), 32'h1);
    chk("mid_tag_pre",   32'(CDB_tag), 32'(T1));
    #2;
    reset = 1'b0;
    #1;
    chk("mid_valid_async", 32'(CDB_valid), 32'h0);
    chk("mid_tag_async",   32'(CDB_tag), 32'h0);
    chk("mid_data_async",  CDB_data, 32'h0);
    chk("mid_grant_rst",   32'(grant), 32'h0);
    $display("async reset: cdb_valid=%b grant=%b", CDB_valid, grant);
    @(posedge clk); #1;
    reset = 1'b1;
    // ptr back at 0: full contention picks unit 0 first
    req = 4'b1111;
    #3;
    chk("post_rst_grant", 32'(grant), 32'b0001);
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(CDB_valid), 32'h1);
    chk("post_rst_tag",   32'(CDB_tag), 32'(T0));
    $display("post reset: grant=0001 expected, cdb_tag=%0d", CDB_tag);
    req = 4'b0000;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single Common Data Bus (CDB) among the four functional units: integer, ld_st, mul and div.
- Each cycle it selects one requesting unit by round-robin and registers that unit's tag and result onto the CDB.
- It drives CDB_tag/CDB_valid/CDB_data/CDB_branch/CDB_branch_taken, which are consumed by the front end (dispatch/register status) and the issue queues.
- It gives requesters a one-hot grant so they can retire their result and advance.

Parameters:
- NUM_REQ, 4, number of requesting functional units (index 0=integer, 1=ld_st, 2=mul, 3=div).
- TAG_WIDTH, 6, rename tag width.
- DATA_WIDTH, 32, result width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-unit result-ready request.
- req_tag  input  NUM_REQ*TAG_WIDTH  flattened tags; unit i occupies bits [i*TAG_WIDTH +: TAG_WIDTH].
- req_data  input  NUM_REQ*DATA_WIDTH  flattened results; same slicing as req_tag.
- int_branch  input  1  integer unit's result is a branch.
- int_branch_taken  input  1  integer unit's branch resolved taken.
- flush  input  1  suppress arbitration this cycle.
- grant  output  NUM_REQ  one-hot combinational grant.
- CDB_valid  output  1  broadcast valid.
- CDB_tag  output  TAG_WIDTH  broadcast tag.
- CDB_data  output  DATA_WIDTH  broadcast result.
- CDB_branch  output  1  broadcast is a branch.
- CDB_branch_taken  output  1  branch outcome.

Behaviour:
- Reset (reset=0, asynchronous): CDB_valid=0, CDB_tag=0, CDB_data=0, CDB_branch=0, CDB_branch_taken=0, priority pointer ptr=0. grant=0 while reset is low.
- Grant (combinational):
  - Scan indices ptr, ptr+1, … mod NUM_REQ; the first i with req[i]=1 gets grant[i]=1.
  - At most one grant bit is set. grant=0 if no request or flush=1.
- Latency: a grant in cycle N gives CDB_valid=1 and winner payload in cycle N+1, valid for exactly one cycle per grant.
- Requester handshake:
  - req, tag and data stay stable until the cycle grant[i]=1 is seen.
  - The requester may present a new request the next cycle.
  - Deasserting req without a grant is illegal, except in a cycle where flush=1.
- On a grant edge:
  - ptr <= (winner+1) mod NUM_REQ.
  - CDB_tag/CDB_data <= winner slice.
  - CDB_branch/CDB_branch_taken <= int_branch/int_branch_taken if winner=0, else 0.
- No grant (idle or flush): CDB_valid <= 0, CDB_branch <= 0, CDB_branch_taken <= 0. CDB_tag/CDB_data hold their last values. ptr holds.
- Back-to-back grants: the same unit can win consecutive cycles only if no other unit requests.
- Fairness: a continuously requesting unit is granted within NUM_REQ cycles.
- Simultaneous all-request: grant order from ptr=0 is 0,1,2,3,0,…
- Reset mid-broadcast: CDB_valid drops immediately (asynchronous); the pending result is not broadcast, and the requester re-requests after reset.
- ptr wrap-around: NUM_REQ-1 → 0. Non-power-of-2 NUM_REQ is supported.

Optional Feature:
- Macro: CDB_PERF_CNT_EN.
- Defined:
  - Adds per-unit 16-bit saturating grant counters and a 16-bit saturating conflict counter (cycles with ≥2 req bits set and flush=0).
  - Exposes them on output ports perf_grant_cnt (NUM_REQ*16) and perf_conflict_cnt (16).
  - All counters are cleared on reset and stick at 16'hFFFF.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package cdb_pkg holds:
  - REQ_INT=0, REQ_LDST=1, REQ_MUL=2, REQ_DIV=3.
  - CDB_TAG_WIDTH=6, CDB_DATA_WIDTH=32.
  - A typedef for a CDB broadcast struct {valid, tag, data, branch, branch_taken}.
- One sub-module, rr_pick: a combinational rotate-priority one-hot picker (inputs req and ptr; outputs grant and winner index).
- The pointer, CDB registers and perf counters stay in cdb_arbiter.

Test Plan:
- Reset: hold reset=0 with req=4'b1111 → grant=0, CDB_valid=0, CDB_tag=0, CDB_data=0. After release, first grant=4'b0001.
- Single requester: req=4'b0100, tag slot 2=6'd17, data=32'hDEADBEEF → grant=4'b0100 same cycle; next cycle CDB_valid=1, CDB_tag=17, CDB_data=32'hDEADBEEF, CDB_branch=0.
- Full contention: req=4'b1111 held for 8 cycles → grants 0,1,2,3,0,1,2,3; CDB_valid=1 on all 8 following cycles.
- Branch broadcast:
  - Integer wins with int_branch=1, int_branch_taken=1 → CDB_branch=1, CDB_branch_taken=1 for one cycle.
  - mul wins while int_branch=1 → CDB_branch=0.
- Flush: req=4'b1010 with flush=1 → grant=0, next CDB_valid=0, ptr unchanged. Flush drops → grant=4'b0010.
- Async reset mid-operation: assert reset=0 between clock edges while CDB_valid=1 → CDB_valid=0 immediately and ptr=0.
